// File: rtl/jtframe_vumeter_pkg.sv
// Shared types and constants for the multichannel VU meter.
package jtframe_vumeter_pkg;

    localparam int unsigned BARW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/jtframe_vumeter_bar.sv
// One channel's bar: leading-one detect on the accumulator top bits,
// ballistic bar count (instant attack, one-bar decay) and thermometer output.
module jtframe_vumeter_bar
    import jtframe_vumeter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_upd,
    input  logic [BARW-1:0] i_top,
    output logic [BARW-1:0] o_vu
);

    logic [3:0] r_n;
    logic [3:0] w_n;

    // Bit i set as the highest one gives i+1 bars
    always_comb begin
        w_n = '0;
        for (int unsigned i = 0; i < BARW; i++) begin
            if (i_top[i]) w_n = 4'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n <= '0;
        end else if (i_upd) begin
            r_n <= (w_n >= r_n) ? w_n : r_n - 4'd1;
        end
    end

    always_comb begin
        o_vu = '0;
        for (int unsigned i = 0; i < BARW; i++) begin
            o_vu[i] = (4'(i) < r_n);
        end
    end

endmodule

// File: rtl/jtframe_vumeter_mc.sv
// Multichannel VU meter: one shared squarer/abs stage walks the channels per
// sample, integrates over a window and drives a bar plus peak flag per channel.
module jtframe_vumeter_mc
    import jtframe_vumeter_pkg::*;
#(
    parameter int unsigned CH   = 2,
    parameter int unsigned W    = 16,
    parameter int unsigned WIN  = 13,
    parameter int unsigned HOLD = 6
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               cen,
    input  logic               mode,
    input  logic [CH*W-1:0]    snd,
    output logic [CH*BARW-1:0] vu,
    output logic [CH-1:0]      peak,
    output logic               busy
);

    localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned AW = W + WIN;
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    state_t                r_state, w_next;
    logic [IW-1:0]         r_idx, r_pidx;
    logic                  r_pvalid, r_mode;
    logic [CH*W-1:0]       r_snd;
    logic [W-1:0]          r_prod;
    logic [AW-1:0]         r_acc [CH];
    logic [WIN-1:0]        r_win;
    logic [HOLD-1:0]       r_hold [CH];
    logic [CH-1:0]         r_peak;

    logic                  w_idle, w_run, w_upd, w_wend;
    logic signed [W-1:0]   w_s;
    logic signed [2*W-1:0] w_sq;
    logic [W-1:0]          w_mag, w_term;
    logic [CH-1:0]         w_fs;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (cen) w_next = ST_RUN;
            ST_RUN:    if (r_idx == IW'(CH-1)) w_next = ST_FLUSH;
            ST_FLUSH:  w_next = ST_UPDATE;
            ST_UPDATE: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle = (r_state == ST_IDLE);
        w_run  = (r_state == ST_RUN);
        w_upd  = (r_state == ST_UPDATE);
        busy   = !w_idle;
    end

    assign w_wend = w_upd && (r_win == '1);

    // Shared term stage: mode 0 keeps s*s bits [2W-2 -: W], mode 1 is the clamped magnitude doubled
    always_comb begin
        w_s  = r_snd[r_idx*W +: W];
        w_sq = (2*W)'(w_s) * (2*W)'(w_s);
        if (w_s == SMIN)   w_mag = SMAX;
        else if (w_s[W-1]) w_mag = -w_s;
        else               w_mag = w_s;
        w_term = r_mode ? W'({w_mag, 1'b0}) : W'(w_sq >> (W-1));
    end

    always_comb begin
        w_fs = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            w_fs[k] = (r_snd[k*W +: W] == SMAX) || (r_snd[k*W +: W] == SMIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snd    <= '0;
            r_mode   <= 1'b0;
            r_idx    <= '0;
            r_pidx   <= '0;
            r_pvalid <= 1'b0;
            r_prod   <= '0;
            r_win    <= '0;
            r_peak   <= '0;
            for (int unsigned k = 0; k < CH; k++) begin
                r_acc[k]  <= '0;
                r_hold[k] <= '0;
            end
        end else begin
            if (w_idle && cen) begin
                r_snd  <= snd;
                r_mode <= mode;
            end
            r_idx    <= w_run ? r_idx + IW'(1) : '0;
            r_pvalid <= w_run;
            r_pidx   <= r_idx;
            r_prod   <= w_term;
            // The last channel's accumulate lands in FLUSH, so UPDATE sees every term of the pass
            if (r_pvalid) r_acc[r_pidx] <= r_acc[r_pidx] + AW'(r_prod);
            if (w_upd) begin
                r_win <= r_win + WIN'(1);
                for (int unsigned k = 0; k < CH; k++) begin
                    if (w_wend) r_acc[k] <= '0;
                    if (w_fs[k]) begin
                        r_peak[k] <= 1'b1;
                        r_hold[k] <= '0;
                    end else begin
                        r_hold[k] <= r_hold[k] + HOLD'(1);
                        if (r_hold[k] == '1) r_peak[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign peak = r_peak;

    for (genvar k = 0; k < CH; k++) begin : g_bar
        jtframe_vumeter_bar u_bar (
            .clk   (clk),
            .rst   (rst),
            .i_upd (w_wend),
            .i_top (r_acc[k][AW-1 -: BARW]),
            .o_vu  (vu[k*BARW +: BARW])
        );
    end

endmodule

// File: tb/tb_jtframe_vumeter_mc.sv
// Scoreboard bench for jtframe_vumeter_mc (CH=2, W=16, WIN=4, HOLD=2, cen every 8 clk).
module tb_jtframe_vumeter_mc;

    localparam int unsigned CH   = 2;
    localparam int unsigned W    = 16;
    localparam int unsigned WIN  = 4;
    localparam int unsigned HOLD = 2;

    logic              rst, clk, cen, mode;
    logic [CH*W-1:0]   snd;
    logic [CH*8-1:0]   vu;
    logic [CH-1:0]     peak;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] vu;
        logic [1:0]  peak;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int   m_acc  [CH];
    int   m_bar  [CH];
    int   m_hold [CH];
    bit   m_peak [CH];
    int   m_win;

    bit   in_abort;
    int   busy_cnt;
    logic busy_d;
    logic [7:0] decay [8];

    jtframe_vumeter_mc #(
        .CH   (CH),
        .W    (W),
        .WIN  (WIN),
        .HOLD (HOLD)
    ) dut (
        .rst  (rst),
        .clk  (clk),
        .cen  (cen),
        .mode (mode),
        .snd  (snd),
        .vu   (vu),
        .peak (peak),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int term_of(input logic signed [15:0] s, input logic md);
        longint v, a;
        v = s;
        if (!md) return int'((v * v) >> 15);
        a = (v < 0) ? -v : v;
        if (a > 32767) a = 32767;
        return int'(a * 2);
    endfunction

    function automatic int bars_of(input int acc);
        int top, n;
        top = (acc >> 12) & 8'hFF;
        n = 0;
        while (top > 0) begin
            n++;
            top = top >> 1;
        end
        return n;
    endfunction

    function automatic logic signed [15:0] rnd_sample();
        case ($urandom_range(0, 5))
            0:       return 16'sh7FFF;
            1:       return 16'sh8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_acc[k]  = 0;
            m_bar[k]  = 0;
            m_hold[k] = 0;
            m_peak[k] = 1'b0;
        end
        m_win = 0;
        sb_q.delete();
    endtask

    task automatic model_pass(input logic signed [15:0] s0, input logic signed [15:0] s1, input logic md);
        logic signed [15:0] s [CH];
        exp_t e;
        int n;
        s[0] = s0;
        s[1] = s1;
        e.vu = '0;
        e.peak = '0;
        for (int k = 0; k < CH; k++) begin
            m_acc[k] += term_of(s[k], md);
            if (m_win == 15) begin
                n = bars_of(m_acc[k]);
                m_bar[k] = (n >= m_bar[k]) ? n : m_bar[k] - 1;
                m_acc[k] = 0;
            end
            if (s[k] == 16'sh7FFF || s[k] == 16'sh8000) begin
                m_peak[k] = 1'b1;
                m_hold[k] = 0;
            end else begin
                if (m_hold[k] == 3) m_peak[k] = 1'b0;
                m_hold[k] = (m_hold[k] + 1) % 4;
            end
            e.vu[k*8 +: 8] = 8'((1 << m_bar[k]) - 1);
            e.peak[k] = m_peak[k];
        end
        m_win = (m_win + 1) % 16;
        sb_q.push_back(e);
    endtask

    task automatic run_pass(input logic signed [15:0] s0, input logic signed [15:0] s1, input logic md);
        @(negedge clk);
        cen  = 1'b1;
        mode = md;
        snd  = {s1, s0};
        model_pass(s0, s1, md);
        @(negedge clk);
        cen = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Results are collected on the first idle cycle after each pass
    always @(negedge clk) begin
        if (in_abort) begin
            busy_cnt = 0;
            busy_d   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (busy_d && !busy) begin
                check("busy_len", busy_cnt, CH + 2);
                busy_cnt = 0;
                check("sb_avail", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("vu", vu, mon_e.vu);
                    check("peak", peak, mon_e.peak);
                end
            end
            busy_d = busy;
        end
    end

    initial begin
        rst = 1'b1; cen = 1'b0; mode = 1'b0; snd = '0;
        in_abort = 1'b0; busy_cnt = 0; busy_d = 1'b0;
        decay = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
        model_reset();
        do_reset();
        check("rst_vu", vu, 0);
        check("rst_peak", peak, 0);
        check("rst_busy", busy, 0);

        repeat (16) run_pass(16'sh4000, 16'sh0000, 1'b0);
        check("ms_4000", vu, 16'h003F);

        repeat (16) run_pass(16'sh8000, 16'sh0000, 1'b0);
        check("ms_fullscale", vu[7:0], 8'hFF);
        for (int w = 0; w < 8; w++) begin
            repeat (16) run_pass(16'sh0000, 16'sh0000, 1'b0);
            check("decay", vu[7:0], decay[w]);
        end

        for (int i = 0; i < 6; i++) begin
            run_pass(16'sh0000, (i == 0) ? 16'sh7FFF : 16'sh0000, 1'b0);
            check("peak1_hold", peak[1], (i < 4));
            check("peak0_quiet", peak[0], 0);
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_pass(16'sh4000, (i == 15) ? 16'sh8000 : 16'sh0000, 1'b1);
        end
        check("mabs_vu", vu, 16'h0FFF);
        check("mabs_peak", peak, 2'b10);

        // Second cen while busy carries a full-scale ch0 that must not be latched
        @(negedge clk);
        cen = 1'b1; mode = 1'b0; snd = '0;
        model_pass(16'sh0000, 16'sh0000, 1'b0);
        @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
        cen = 1'b1; snd = {16'h0000, 16'h7FFF};
        @(negedge clk);
        cen = 1'b0; snd = '0;
        repeat (4) @(negedge clk);
        check("dbl_peak0", peak[0], 0);

        @(negedge clk);
        cen = 1'b1; mode = 1'b0; snd = {16'h0000, 16'h8000};
        @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_abort = 1'b1;
        @(negedge clk);
        check("abort_vu", vu, 0);
        check("abort_peak", peak, 0);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        in_abort = 1'b0;

        repeat (16) run_pass(16'sh4000, 16'sh0000, 1'b0);
        check("fresh_vu", vu, 16'h003F);

        repeat (32) run_pass(rnd_sample(), rnd_sample(), 1'($urandom_range(0, 1)));

        repeat (4) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
